// File: rtl/membus_fairness_monitor_if.sv
// MemBus cmd/rsp handshake bundle for NCH channels; the fairness monitor
// attaches through the passive mon modport.
interface membus_fairness_monitor_if #(
    parameter int NCH = 2
);
    logic [NCH-1:0] cmd_valid;
    logic [NCH-1:0] cmd_ready;
    logic [NCH-1:0] cmd_write;
    logic [NCH-1:0] rsp_valid;

    modport master (output cmd_valid, output cmd_write, input cmd_ready, input rsp_valid);
    modport slave  (input cmd_valid, input cmd_write, output cmd_ready, output rsp_valid);
    modport mon    (input cmd_valid, input cmd_ready, input cmd_write, input rsp_valid);
endinterface

// File: rtl/membus_fairness_monitor.sv
// Passive MemBus protocol/fairness monitor: outstanding tracking, wait bounds,
// sticky violation flags and first-error capture. MEMBUS_FAIRNESS_ASSUME_EN adds formal assumes.
module membus_fairness_monitor #(
    parameter int NCH             = 2,
    parameter int MAX_OUTSTANDING = 1,
    parameter int MAX_CMD_WAIT    = 4,
    parameter int MAX_RSP_WAIT    = 4,
    parameter int TRACK_WRITES    = 0,
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1),
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    membus_fairness_monitor_if.mon bus,
    output logic [NCH*CW-1:0]     outstanding,
    output logic [NCH-1:0]        cmd_stall_err,
    output logic [NCH-1:0]        rsp_latency_err,
    output logic [NCH-1:0]        spurious_rsp_err,
    output logic [NCH-1:0]        overflow_err,
    output logic [NCH-1:0]        cycle_legal,
    output logic                  any_err,
    output logic                  first_err_valid,
    output logic [CHW-1:0]        first_err_chan,
    output logic [1:0]            first_err_code
);
    localparam int CMW = $clog2(MAX_CMD_WAIT + 1);
    localparam int RMW = $clog2(MAX_RSP_WAIT + 1);
    localparam logic [CW-1:0]  OUT_MAX  = CW'(MAX_OUTSTANDING);
    localparam logic [CMW-1:0] CMD_MAX  = CMW'(MAX_CMD_WAIT);
    localparam logic [CMW-1:0] CMD_LAST = CMW'(MAX_CMD_WAIT - 1);
    localparam logic [RMW-1:0] RSP_MAX  = RMW'(MAX_RSP_WAIT);
    localparam logic [RMW-1:0] RSP_LAST = RMW'(MAX_RSP_WAIT - 1);

    typedef enum logic [1:0] {
        ERR_STALL    = 2'd0,
        ERR_LATENCY  = 2'd1,
        ERR_SPURIOUS = 2'd2,
        ERR_OVERFLOW = 2'd3
    } err_code_e;

    logic [CW-1:0]  r_out      [NCH];
    logic [CMW-1:0] r_cmd_wait [NCH];
    logic [RMW-1:0] r_rsp_wait [NCH];
    logic [NCH-1:0] r_stall, r_lat, r_spur, r_ovf;
    logic           r_any, r_first_valid;
    logic [CHW-1:0] r_first_chan;
    err_code_e      r_first_code;

    logic [NCH-1:0] w_acc, w_owed, w_stalled, w_rsp;
    logic [NCH-1:0] w_stall, w_lat, w_spur, w_ovf, w_viol;
    logic           w_found;
    logic [CHW-1:0] w_first_chan;
    err_code_e      w_first_code;

    always_comb begin
        w_acc        = '0;
        w_owed       = '0;
        w_stalled    = '0;
        w_rsp        = bus.rsp_valid;
        w_stall      = '0;
        w_lat        = '0;
        w_spur       = '0;
        w_ovf        = '0;
        w_found      = 1'b0;
        w_first_chan = '0;
        w_first_code = ERR_STALL;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_acc[i]     = bus.cmd_valid[i] && bus.cmd_ready[i] && (TRACK_WRITES != 0 || !bus.cmd_write[i]);
            w_owed[i]    = (r_out[i] != '0) || w_acc[i];
            w_stalled[i] = bus.cmd_valid[i] && !bus.cmd_ready[i];
            w_stall[i]   = w_stalled[i] && (r_cmd_wait[i] == CMD_LAST);
            w_lat[i]     = w_owed[i] && !w_rsp[i] && (r_rsp_wait[i] == RSP_LAST);
            w_spur[i]    = w_rsp[i] && (r_out[i] == '0) && !w_acc[i];
            w_ovf[i]     = w_acc[i] && (r_out[i] == OUT_MAX) && !w_rsp[i];
            w_viol[i]    = w_stall[i] | w_lat[i] | w_spur[i] | w_ovf[i];
            // lowest channel wins; within it spurious > overflow > latency > stall
            if (!w_found && w_viol[i]) begin
                w_found      = 1'b1;
                w_first_chan = CHW'(i);
                w_first_code = w_spur[i] ? ERR_SPURIOUS :
                               w_ovf[i]  ? ERR_OVERFLOW :
                               w_lat[i]  ? ERR_LATENCY  : ERR_STALL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                r_out[i]      <= '0;
                r_cmd_wait[i] <= '0;
                r_rsp_wait[i] <= '0;
            end
            r_stall       <= '0;
            r_lat         <= '0;
            r_spur        <= '0;
            r_ovf         <= '0;
            r_any         <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_chan  <= '0;
            r_first_code  <= ERR_STALL;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (w_acc[i] && !w_rsp[i]) begin
                    if (r_out[i] != OUT_MAX) r_out[i] <= r_out[i] + 1'b1;
                end else if (!w_acc[i] && w_rsp[i] && r_out[i] != '0) begin
                    r_out[i] <= r_out[i] - 1'b1;
                end

                if (!w_stalled[i])                r_cmd_wait[i] <= '0;
                else if (r_cmd_wait[i] != CMD_MAX) r_cmd_wait[i] <= r_cmd_wait[i] + 1'b1;

                if (w_rsp[i] || !w_owed[i])        r_rsp_wait[i] <= '0;
                else if (r_rsp_wait[i] != RSP_MAX) r_rsp_wait[i] <= r_rsp_wait[i] + 1'b1;
            end
            r_stall <= r_stall | w_stall;
            r_lat   <= r_lat   | w_lat;
            r_spur  <= r_spur  | w_spur;
            r_ovf   <= r_ovf   | w_ovf;
            r_any   <= |{r_stall | w_stall, r_lat | w_lat, r_spur | w_spur, r_ovf | w_ovf};
            if (!r_first_valid && w_found) begin
                r_first_valid <= 1'b1;
                r_first_chan  <= w_first_chan;
                r_first_code  <= w_first_code;
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            outstanding[i*CW +: CW] = r_out[i];
        end
    end

    assign cmd_stall_err    = r_stall;
    assign rsp_latency_err  = r_lat;
    assign spurious_rsp_err = r_spur;
    assign overflow_err     = r_ovf;
    assign cycle_legal      = ~w_viol;
    assign any_err          = r_any;
    assign first_err_valid  = r_first_valid;
    assign first_err_chan   = r_first_chan;
    assign first_err_code   = r_first_code;

`ifdef MEMBUS_FAIRNESS_ASSUME_EN
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            assume (cycle_legal[i]);
        end
    end
`endif
endmodule
